chunked_adder_seq: RTL

- Parametrised multi-cycle adder.
- Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, using one reused CHUNK-bit ripple slice.
- Uses valid/ready handshakes on input and output.
- Next-generation replacement for the single-bit combinational adder cell. Used in arithmetic datapaths where area matters more than latency.

---
 rtl/chunked_adder_pkg.sv | 19 +
 rtl/chunked_adder_seq_add_slice.sv | 28 ++
 rtl/chunked_adder_seq.sv | 136 +++++++++++++
 3 files changed

// File: rtl/chunked_adder_pkg.sv
// rtl/chunked_adder_pkg.sv - shared FSM state type and sizing helpers for chunked_adder_seq
package chunked_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Counter needs at least one bit even when a single slice covers the word.
  function automatic int calc_cnt_w(input int nchunk);
    return (nchunk <= 2) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/chunked_adder_seq_add_slice.sv
// rtl/chunked_adder_seq_add_slice.sv - combinational CHUNK-bit ripple adder slice
module add_slice #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] w_c;

  always_comb begin
    w_c    = '0;
    w_c[0] = ci;
    s      = '0;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]     = x[i] ^ y[i] ^ w_c[i];
      w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
    end
  end

  assign co    = w_c[CHUNK];
  assign c_msb = w_c[CHUNK-1];

endmodule

// File: rtl/chunked_adder_seq.sv
// rtl/chunked_adder_seq.sv - multi-cycle adder, CHUNK bits per clock through one reused slice
// Optional subtract mode (op port) enabled by defining ADDER_SUB_EN.
module chunked_adder_seq
  import chunked_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int CNT_W  = calc_cnt_w(NCHUNK);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [WIDTH-1:0] w_b_in;
  logic             w_c_in;
  logic [CHUNK-1:0] w_x;
  logic [CHUNK-1:0] w_y;
  logic [CHUNK-1:0] w_s;
  logic             w_co;
  logic             w_cmsb;

  // Subtraction is folded into the operands at accept: a + ~b + ~cin.
`ifdef ADDER_SUB_EN
  assign w_b_in = op ? ~b : b;
  assign w_c_in = op ? ~cin : cin;
`else
  assign w_b_in = b;
  assign w_c_in = cin;
`endif

  assign w_x = CHUNK'(r_a >> (int'(r_cnt) * CHUNK));
  assign w_y = CHUNK'(r_b >> (int'(r_cnt) * CHUNK));

  add_slice #(.CHUNK(CHUNK)) u_slice (
    .x    (w_x),
    .y    (w_y),
    .ci   (r_carry),
    .s    (w_s),
    .co   (w_co),
    .c_msb(w_cmsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= w_b_in;
            r_carry    <= w_c_in;
            r_sum      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ADD;
          end
        end
        ADD: begin
          r_sum[int'(r_cnt)*CHUNK +: CHUNK] <= w_s;
          r_carry <= w_co;
          if (r_cnt == LAST) begin
            r_cout      <= w_co;
            r_ovf       <= w_cmsb ^ w_co;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule
